// File: rtl/z80_insn_framer.sv
// Z80 instruction framer: assembles fetched bytes into whole instructions (prefixes and
// operands included) and queues them with length and start address in a small FIFO.
module z80_insn_framer #(
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [7:0]        i_in_data,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [31:0]       o_out_instr,
    output logic [2:0]        o_out_len,
    output logic              o_out_orphan,
    output logic [ADDR_W-1:0] o_out_pc
);

    localparam int unsigned PW   = $clog2(OUT_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(OUT_DEPTH);

    function automatic logic f_is_ix(input logic [7:0] b);
        return (b == 8'hDD) || (b == 8'hFD);
    endfunction

    // b1 is only meaningful for prefixed opcodes; unprefixed lengths depend on b0 alone.
    function automatic logic [2:0] f_need_len(input logic [7:0] b0, input logic [7:0] b1);
        logic [2:0] len;
        len = 3'd1;
        if (b0 == 8'hCB) begin
            len = 3'd2;
        end else if (b0 == 8'hED) begin
            len = ((b1 & 8'hC7) == 8'h43) ? 3'd4 : 3'd2;
        end else if (f_is_ix(b0)) begin
            case (b1)
                8'hCB, 8'h21, 8'h22, 8'h2A, 8'h36: len = 3'd4;
                8'h34, 8'h35, 8'h46, 8'h4E, 8'h56, 8'h5E, 8'h66, 8'h6E, 8'h7E,
                8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h77,
                8'h86, 8'h8E, 8'h96, 8'h9E, 8'hA6, 8'hAE, 8'hB6, 8'hBE: len = 3'd3;
                default: len = 3'd2;
            endcase
        end else if (((b0 & 8'hCF) == 8'h01) || ((b0 & 8'hC7) == 8'hC2) ||
                     ((b0 & 8'hC7) == 8'hC4) ||
                     (b0 inside {8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD})) begin
            len = 3'd3;
        end else if (((b0 & 8'hC7) == 8'h06) || ((b0 & 8'hC7) == 8'hC6) ||
                     (b0 inside {8'hD3, 8'hDB, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38})) begin
            len = 3'd2;
        end
        return len;
    endfunction

    logic [7:0]        r_buf [4];
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_start_pc;

    logic [31:0]       r_f_instr  [OUT_DEPTH];
    logic [2:0]        r_f_len    [OUT_DEPTH];
    logic              r_f_orphan [OUT_DEPTH];
    logic [ADDR_W-1:0] r_f_pc     [OUT_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;

    logic              w_accept;
    logic              w_pop;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [2:0]        w_need;
    logic              w_orphan;
    logic              w_done;
    logic              w_push;
    logic [31:0]       w_word;
    logic [31:0]       w_push_instr;
    logic [2:0]        w_push_len;

    assign o_in_ready  = !i_flush && (r_count != FULL);
    assign o_out_valid = (r_count != '0);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready && !i_flush;

    // Length decode sees the buffer as if the incoming byte were already stored.
    assign w_b0     = (r_cnt == 2'd0) ? i_in_data : r_buf[0];
    assign w_b1     = (r_cnt == 2'd1) ? i_in_data : r_buf[1];
    assign w_need   = f_need_len(w_b0, w_b1);
    assign w_orphan = (r_cnt == 2'd1) && f_is_ix(r_buf[0]) &&
                      (i_in_data inside {8'hDD, 8'hED, 8'hFD});
    assign w_done   = (({1'b0, r_cnt}) + 3'd1) == w_need;
    assign w_push   = w_accept && (w_orphan || w_done);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(r_cnt)) w_word[8*i +: 8] = r_buf[i];
        end
        w_word[{r_cnt, 3'b000} +: 8] = i_in_data;
    end

    assign w_push_instr = w_orphan ? {24'h0, r_buf[0]} : w_word;
    assign w_push_len   = w_orphan ? 3'd1 : w_need;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= 8'h00;
            r_cnt      <= 2'd0;
            r_pc       <= '0;
            r_start_pc <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (i_flush) begin
            r_cnt      <= 2'd0;
            r_pc       <= i_flush_pc;
            r_start_pc <= i_flush_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + ADDR_W'(1);
                if (w_orphan) begin
                    // The superseding prefix starts the next instruction.
                    r_buf[0]   <= i_in_data;
                    r_cnt      <= 2'd1;
                    r_start_pc <= r_pc;
                end else if (w_done) begin
                    r_cnt      <= 2'd0;
                    r_start_pc <= r_pc + ADDR_W'(1);
                end else begin
                    r_buf[r_cnt] <= i_in_data;
                    r_cnt        <= r_cnt + 2'd1;
                end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_f_instr[r_wr_ptr]  <= w_push_instr;
            r_f_len[r_wr_ptr]    <= w_push_len;
            r_f_orphan[r_wr_ptr] <= w_orphan;
            r_f_pc[r_wr_ptr]     <= r_start_pc;
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    assign o_out_instr  = o_out_valid ? r_f_instr[r_rd_ptr]  : '0;
    assign o_out_len    = o_out_valid ? r_f_len[r_rd_ptr]    : '0;
    assign o_out_orphan = o_out_valid ? r_f_orphan[r_rd_ptr] : 1'b0;
    assign o_out_pc     = o_out_valid ? r_f_pc[r_rd_ptr]     : '0;

endmodule

// File: tb/tb_z80_insn_framer.sv
// Bench for z80_insn_framer: directed scenarios plus randomized traffic against a
// table-driven instruction-length model and a queue-based output scoreboard.
module tb_z80_insn_framer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        flush = 1'b0;
    logic [15:0] flush_pc = 16'h0000;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [2:0]  out_len;
    logic        out_orphan;
    logic [15:0] out_pc;

    z80_insn_framer #(
        .OUT_DEPTH (DEPTH),
        .ADDR_W    (16)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .i_flush      (flush),
        .i_flush_pc   (flush_pc),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_instr  (out_instr),
        .o_out_len    (out_len),
        .o_out_orphan (out_orphan),
        .o_out_pc     (out_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    int          u_len [256];
    int          x_len [256];
    logic [7:0]  m_bytes [$];
    logic [15:0] m_pc;
    logic [15:0] m_start;
    logic [31:0] q_instr [$];
    int          q_len [$];
    bit          q_orph [$];
    logic [15:0] q_pc [$];
    bit          m_acc;

    initial begin
        for (int i = 0; i < 256; i++) begin
            u_len[i] = 1;
            x_len[i] = 2;
        end
        for (int k = 0; k < 8; k++) begin
            u_len[8'h06 + 8*k] = 2;
            u_len[8'hC6 + 8*k] = 2;
            u_len[8'hC2 + 8*k] = 3;
            u_len[8'hC4 + 8*k] = 3;
        end
        foreach (u_len[i]) begin
            if (i inside {'hD3, 'hDB, 'h10, 'h18, 'h20, 'h28, 'h30, 'h38}) u_len[i] = 2;
            if (i inside {'h01, 'h11, 'h21, 'h31, 'h22, 'h2A, 'h32, 'h3A, 'hC3, 'hCD})
                u_len[i] = 3;
            if (i inside {'hCB, 'h21, 'h22, 'h2A, 'h36}) x_len[i] = 4;
            if (i inside {'h34, 'h35, 'h46, 'h4E, 'h56, 'h5E, 'h66, 'h6E, 'h7E, 'h77,
                          ['h70:'h75], 'h86, 'h8E, 'h96, 'h9E, 'hA6, 'hAE, 'hB6, 'hBE})
                x_len[i] = 3;
        end
    end

    function automatic int ref_len();
        logic [7:0] b0;
        b0 = m_bytes[0];
        if (b0 == 8'hCB) return 2;
        if (b0 == 8'hED) begin
            if (m_bytes.size() < 2) return 2;
            return (m_bytes[1] inside {8'h43, 8'h4B, 8'h53, 8'h5B, 8'h63, 8'h6B, 8'h73, 8'h7B})
                   ? 4 : 2;
        end
        if (b0 == 8'hDD || b0 == 8'hFD) begin
            if (m_bytes.size() < 2) return 2;
            return x_len[m_bytes[1]];
        end
        return u_len[b0];
    endfunction

    task automatic model_clear();
        m_bytes.delete();
        q_instr.delete();
        q_len.delete();
        q_orph.delete();
        q_pc.delete();
    endtask

    task automatic model_emit(input logic [31:0] w, input int len, input bit orph,
                              input logic [15:0] pc);
        q_instr.push_back(w);
        q_len.push_back(len);
        q_orph.push_back(orph);
        q_pc.push_back(pc);
    endtask

    task automatic model_frame(input logic [7:0] b);
        logic [31:0] w;
        m_bytes.push_back(b);
        if (m_bytes.size() == 2 && (m_bytes[0] == 8'hDD || m_bytes[0] == 8'hFD) &&
            (b == 8'hDD || b == 8'hED || b == 8'hFD)) begin
            model_emit({24'h0, m_bytes[0]}, 1, 1'b1, m_start);
            m_bytes.delete();
            m_bytes.push_back(b);
            m_start = m_pc;
        end else if (m_bytes.size() == ref_len()) begin
            w = 32'h0;
            for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
            model_emit(w, m_bytes.size(), 1'b0, m_start);
            m_bytes.delete();
            m_start = m_pc + 16'd1;
        end
        m_pc = m_pc + 16'd1;
    endtask

    task automatic model_edge();
        bit acc;
        m_acc = 1'b0;
        if (!reset_n) begin
            model_clear();
            m_pc = 16'h0;
            m_start = 16'h0;
        end else if (flush) begin
            model_clear();
            m_pc = flush_pc;
            m_start = flush_pc;
        end else begin
            acc = in_valid && (q_instr.size() < DEPTH);
            if (out_ready && q_instr.size() != 0) begin
                void'(q_instr.pop_front());
                void'(q_len.pop_front());
                void'(q_orph.pop_front());
                void'(q_pc.pop_front());
            end
            if (acc) model_frame(in_data);
            m_acc = acc;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic auto_check();
        check_eq("out_valid", out_valid, q_instr.size() != 0);
        check_eq("in_ready", in_ready, !flush && (q_instr.size() < DEPTH));
        if (q_instr.size() != 0) begin
            check_eq("head_instr", out_instr, q_instr[0]);
            check_eq("head_len", out_len, q_len[0]);
            check_eq("head_orphan", out_orphan, q_orph[0]);
            check_eq("head_pc", out_pc, q_pc[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        auto_check();
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 16; k++) begin
            step();
            if (m_acc) break;
        end
        if (!m_acc) check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] w, input logic [2:0] len,
                              input logic orph, input logic [15:0] pc);
        for (int k = 0; k < 8 && !out_valid; k++) step();
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_instr"}, out_instr, w);
        check_eq({tag, "_len"}, out_len, len);
        check_eq({tag, "_orphan"}, out_orphan, orph);
        check_eq({tag, "_pc"}, out_pc, pc);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_instr"}, out_instr, 0);
        check_eq({tag, "_len"}, out_len, 0);
        check_eq({tag, "_orphan"}, out_orphan, 0);
        check_eq({tag, "_pc"}, out_pc, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Asserted away from the clock edge so the asynchronous path is what clears state.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_clear();
        m_pc = 16'h0;
        m_start = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        m_pc = 16'h0;
        m_start = 16'h0;
        #2;
        do_reset("reset");

        send(8'h00);
        check_eq("nop_latency_valid", out_valid, 1);
        pop_expect("nop", 32'h0000_0000, 3'd1, 1'b0, 16'h0000);

        do_reset("reset2");
        send(8'h01); send(8'h34); send(8'h12);
        send(8'hED); send(8'h4B); send(8'h00); send(8'h80);
        pop_expect("ld_bc", 32'h0012_3401, 3'd3, 1'b0, 16'h0000);
        pop_expect("ld_bc_mem", 32'h8000_4BED, 3'd4, 1'b0, 16'h0003);

        do_reset("reset3");
        send(8'hDD); send(8'hCB); send(8'h05); send(8'hC6);
        send(8'hED); send(8'hB0);
        pop_expect("ddcb", 32'hC605_CBDD, 3'd4, 1'b0, 16'h0000);
        pop_expect("ldir", 32'h0000_B0ED, 3'd2, 1'b0, 16'h0004);
        send(8'hFD); send(8'h36); send(8'h02); send(8'h7F);
        pop_expect("ld_iy_n", 32'h7F02_36FD, 3'd4, 1'b0, 16'h0006);

        do_reset("reset4");
        send(8'hDD); send(8'hFD); send(8'h7E); send(8'h02);
        pop_expect("orphan", 32'h0000_00DD, 3'd1, 1'b1, 16'h0000);
        pop_expect("ld_a_iy", 32'h0002_7EFD, 3'd3, 1'b0, 16'h0001);

        do_reset("reset5");
        send(8'h00); send(8'h00);
        check_eq("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        pop_expect("full0", 32'h0, 3'd1, 1'b0, 16'h0000);
        send(8'h00);
        pop_expect("full1", 32'h0, 3'd1, 1'b0, 16'h0001);
        pop_expect("full2", 32'h0, 3'd1, 1'b0, 16'h0002);

        do_reset("reset6");
        send(8'h01); send(8'h34);
        flush = 1'b1;
        flush_pc = 16'h8000;
        step();
        flush = 1'b0;
        send(8'h3E); send(8'h55);
        pop_expect("flush", 32'h0000_553E, 3'd2, 1'b0, 16'h8000);

        send(8'h01); send(8'h34);
        do_reset("mid_reset");
        send(8'h3E); send(8'h55);
        pop_expect("after_reset", 32'h0000_553E, 3'd2, 1'b0, 16'h0000);

        flush = 1'b1;
        flush_pc = 16'hFFFE;
        step();
        flush = 1'b0;
        send(8'h01); send(8'h34); send(8'h12); send(8'h00);
        pop_expect("wrap", 32'h0012_3401, 3'd3, 1'b0, 16'hFFFE);
        pop_expect("post_wrap", 32'h0, 3'd1, 1'b0, 16'h0001);

        for (int n = 0; n < 4000; n++) begin
            int r;
            in_valid  = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            case (r)
                0: in_data = 8'hDD;
                1: in_data = 8'hFD;
                2: in_data = 8'hED;
                3: in_data = 8'hCB;
                default: in_data = 8'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            flush_pc  = ($urandom_range(0, 1) != 0) ? 16'hFFFD : 16'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_insn_framer.md
# z80_insn_framer

Byte-stream instruction framer for the Z80 core front end. It accepts opcode/operand bytes one at a time from the fetch unit and works out each instruction's full length, including prefixes and operands. It packs each complete instruction little-endian into a 32-bit word and queues it, with its length and start address, in a parametrised output FIFO for the group decoder and execute stages. Unlike the single-shot length/group lookup, it holds state across bytes, supports the full Z80 length map (CB, ED, DD/FD, DDCB/FDCB), handles orphan prefixes, and supports backpressure and flush.

## Interface
- OUT_DEPTH, 2, output FIFO depth in instructions; power of two, ≥ 2.
- ADDR_W, 16, address width for PC tracking.
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a fetched byte.
- in_ready  out  1  framer accepts the byte this cycle.
- in_data  in  8  instruction byte, in fetch order.
- flush  in  1  discard all partial and queued instructions.
- flush_pc  in  ADDR_W  address of the first byte after flush.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the FIFO head.
- out_instr  out  32  instruction bytes, first byte in [7:0]; unused bytes zero.
- out_len  out  3  instruction length, 1..4.
- out_orphan  out  1  head is a lone DD/FD prefix, emitted as len 1.
- out_pc  out  ADDR_W  address of the instruction's first byte.

## Operation
- Assembly buffer: 4 bytes, byte count cnt (0..3), start address start_pc; running pc advances by 1 on every accepted byte.
- Accept: in_valid & in_ready & !flush. The byte is written at index cnt, and need_len is evaluated on the buffer including the new byte.
- Length map, where b0..b2 are bytes so far:
  - Unprefixed:
    - 2 for 06/0E/16/1E/26/2E/36/3E, C6..FE step 8, D3, DB, 10, 18, 20, 28, 30, 38.
    - 3 for 01/11/21/31, 22, 2A, 32, 3A, C2..FA step 8, C3, C4..FC step 8, CD.
    - Otherwise 1.
  - CB: 2.
  - ED: 4 if (b1 & C7) == 43, else 2.
  - DD/FD:
    - b1 = CB → 4.
    - b1 ∈ {21, 22, 2A, 36} → 4.
    - b1 ∈ {34, 35, 46, 4E, 56, 5E, 66, 6E, 7E, 70..75, 77, 86, 8E, 96, 9E, A6, AE, B6, BE} → 3.
    - b1 ∈ {DD, ED, FD} → orphan.
    - Otherwise 2.
- Completion: when cnt+1 == need_len, push {buffer, need_len, orphan=0, start_pc}, then clear cnt and set start_pc = pc+1.
- Orphan: b0 ∈ {DD, FD} and b1 ∈ {DD, ED, FD}.
  - Push {b0, len 1, orphan=1, start_pc}.
  - In the same cycle, the new byte becomes b0 of the next instruction: cnt=1, start_pc = pc.
  - Chained prefixes therefore emit one orphan per superseded prefix.
- FIFO: OUT_DEPTH entries. Push and pop in the same cycle are allowed when not full. Order is strictly preserved.
- in_ready = !flush & (fifo_count < OUT_DEPTH). It is registered-state derived, with no combinational path from out_ready.
- out_valid = fifo_count != 0. The head fields are stable while out_valid & !out_ready.
- Flush: highest priority.
  - Clears the FIFO and cnt.
  - Loads pc = start_pc = flush_pc.
  - Ignores in_data that cycle.
  - Ignores out_ready that cycle; the head is dropped, not consumed.
- Reset (async, any state including mid-instruction):
  - fifo_count=0, cnt=0, pc=start_pc=0.
  - Outputs: out_valid=0, out_instr=0, out_len=0, out_orphan=0, out_pc=0, in_ready=1.

## Timing
- Latency: final byte accepted at edge N → out_valid high after edge N, visible in cycle N+1 (one-cycle latency with an empty FIFO).
- Throughput: one byte per cycle sustained while the consumer keeps up, so a 1-byte instruction stream runs at 1 instruction/cycle.
- Full FIFO: in_ready drops the cycle after the push that filled it, and rises the cycle after a pop.
- pc wraps modulo 2^ADDR_W. An instruction straddling the wrap keeps its pre-wrap out_pc.
- Flush and a completing byte in the same cycle: flush wins, and the instruction is lost.

## Test plan
- Reset, then 00 → out_instr=0x00000000, len 1, pc 0x0000, out_valid in the cycle after accept.
- 01 34 12, then ED 4B 00 80 → 0x00123401 len 3 pc 0; 0x80004BED len 4 pc 3.
- DD CB 05 C6, then ED B0, then FD 36 02 7F → 0xC605CBDD len 4; 0x0000B0ED len 2; 0x7F0236FD len 4; pcs 0, 4, 6.
- DD FD 7E 02 → orphan DD len 1 pc 0; then 0x00027EFD len 3 pc 1.
- OUT_DEPTH=2, out_ready=0, stream 00 00 00 → in_ready low after the 2nd push; third byte held. Raise out_ready → three len-1 entries at pcs 0, 1, 2 in order.
- After 01 34, assert flush with flush_pc=0x8000, then send 3E 55:
  - Required response: no 3-byte output; 0x0000553E len 2 pc 0x8000.
  - Repeat with reset_n low mid-instruction → all outputs zero, pc restarts at 0.
